cancel_msg_ingest: RTL

//  Front end of the downstream cancel-accounting path. Parses a byte-serial

---
 rtl/cancel_pkg.sv | 28 ++
 rtl/cancel_fifo.sv | 82 ++++++++
 rtl/cancel_msg_ingest.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cancel_pkg.sv
`default_nettype none
// ============================================================================
// Package : cancel_pkg
// Brief   : Shared constants, request struct and parser states for cancel ingest.
// Rev     : 1.0  initial release
// ============================================================================
package cancel_pkg;

    localparam int          CLIENT_W    = 5;
    localparam int          AMT_W       = 32;
    localparam int          AMT_BYTES   = AMT_W / 8;
    localparam int          MSG_LEN     = 2 + AMT_BYTES;
    localparam logic [7:0]  CANCEL_TYPE = 8'h43;

    typedef struct packed {
        logic [CLIENT_W-1:0] client_id;
        logic [AMT_W-1:0]    amount;
    } cancel_req_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLIENT = 2'd1,
        ST_AMT    = 2'd2,
        ST_SKIP   = 2'd3
    } parse_state_t;

endpackage
`default_nettype wire

// File: rtl/cancel_fifo.sv
`default_nettype none
// ============================================================================
// Module : cancel_fifo
// Brief  : Synchronous FIFO of cancel requests with a registered head entry.
// Rev    : 1.0  initial release
// ============================================================================
module cancel_fifo
    import cancel_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  cancel_req_t i_push_data,
    input  logic        i_pop,
    output cancel_req_t o_head,
    output logic        o_full,
    output logic        o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    cancel_req_t       r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    cancel_req_t       r_head;
    logic              r_head_valid;

    logic              w_pop;
    logic              w_push;
    logic [CNT_W-1:0]  w_count_next;
    logic [PTR_W-1:0]  w_rd_ptr_next;
    cancel_req_t       w_head_next;

    assign w_pop         = i_pop && r_head_valid;
    assign w_push        = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);
    assign w_count_next  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_rd_ptr_next = r_rd_ptr + PTR_W'(w_pop);

    // When the entry being written is the only one left, bypass it straight to the head.
    always_comb begin
        w_head_next = r_head;
        if (w_count_next != '0) begin
            if (r_count == CNT_W'(w_pop)) begin
                w_head_next = i_push_data;
            end else begin
                w_head_next = r_mem[w_rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_head       <= '0;
            r_head_valid <= 1'b0;
        end else begin
            r_wr_ptr     <= r_wr_ptr + PTR_W'(w_push);
            r_rd_ptr     <= w_rd_ptr_next;
            r_count      <= w_count_next;
            r_head       <= w_head_next;
            r_head_valid <= (w_count_next != '0);
        end
    end

    assign o_head  = r_head;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = ~r_head_valid;

endmodule
`default_nettype wire

// File: rtl/cancel_msg_ingest.sv
`default_nettype none
// ============================================================================
// Module : cancel_msg_ingest
// Brief  : Parses a byte-serial message stream into buffered cancel requests.
// Rev    : 1.0  initial release
// ============================================================================
module cancel_msg_ingest
    import cancel_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                in_sop,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    output logic                out_valid,
    output logic [CLIENT_W-1:0] client_id,
    output logic [AMT_W-1:0]    amount,
    input  logic                ack,
    output logic [15:0]         msg_count,
    output logic [15:0]         drop_count
);

    localparam int IDX_W = $clog2(MSG_LEN + 1);

    parse_state_t        r_state, w_state_next;
    logic [IDX_W-1:0]    r_byte_idx, w_byte_idx_next;
    logic [CLIENT_W-1:0] r_client, w_client_next;
    logic                r_bad, w_bad_next;
    logic [AMT_W-1:0]    r_amt_sr, w_amt_sr_next;
    logic [15:0]         r_msg_count;
    logic [15:0]         r_drop_count;

    logic                w_accept;
    logic                w_push;
    logic                w_msg_inc;
    logic                w_drop_inc;
    logic                w_full;
    logic                w_empty;
    logic [AMT_W+7:0]    w_shift;
    cancel_req_t         w_push_data;
    cancel_req_t         w_head;

    assign w_accept    = in_valid && !w_full;
    assign w_shift     = {r_amt_sr, in_data};
    assign w_push_data = '{client_id: r_client, amount: w_shift[AMT_W-1:0]};

    always_comb begin
        w_state_next    = r_state;
        w_byte_idx_next = r_byte_idx;
        w_client_next   = r_client;
        w_bad_next      = r_bad;
        w_amt_sr_next   = r_amt_sr;
        w_push          = 1'b0;
        w_msg_inc       = 1'b0;
        w_drop_inc      = 1'b0;
        if (w_accept) begin
            if (in_sop) begin
                // A header always restarts parsing; only a half-parsed cancel counts as dropped.
                if (r_state == ST_CLIENT || r_state == ST_AMT) begin
                    w_drop_inc = 1'b1;
                end
                if (in_data == CANCEL_TYPE) begin
                    w_state_next = ST_CLIENT;
                end else begin
                    w_state_next    = ST_SKIP;
                    w_byte_idx_next = IDX_W'(1);
                end
            end else begin
                case (r_state)
                    ST_CLIENT: begin
                        w_client_next   = in_data[CLIENT_W-1:0];
                        w_bad_next      = |in_data[7:CLIENT_W];
                        w_byte_idx_next = '0;
                        w_state_next    = ST_AMT;
                    end
                    ST_AMT: begin
                        w_amt_sr_next = w_shift[AMT_W-1:0];
                        if (r_byte_idx == IDX_W'(AMT_BYTES - 1)) begin
                            w_state_next = ST_IDLE;
                            if (r_bad) begin
                                w_drop_inc = 1'b1;
                            end else begin
                                w_push    = 1'b1;
                                w_msg_inc = 1'b1;
                            end
                        end else begin
                            w_byte_idx_next = r_byte_idx + IDX_W'(1);
                        end
                    end
                    ST_SKIP: begin
                        if (r_byte_idx == IDX_W'(MSG_LEN - 1)) begin
                            w_state_next = ST_IDLE;
                        end else begin
                            w_byte_idx_next = r_byte_idx + IDX_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_byte_idx   <= '0;
            r_client     <= '0;
            r_bad        <= 1'b0;
            r_amt_sr     <= '0;
            r_msg_count  <= '0;
            r_drop_count <= '0;
        end else begin
            r_state    <= w_state_next;
            r_byte_idx <= w_byte_idx_next;
            r_client   <= w_client_next;
            r_bad      <= w_bad_next;
            r_amt_sr   <= w_amt_sr_next;
            if (w_msg_inc && r_msg_count != 16'hFFFF) begin
                r_msg_count <= r_msg_count + 16'd1;
            end
            if (w_drop_inc && r_drop_count != 16'hFFFF) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    cancel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (ack),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign in_ready   = !w_full;
    assign out_valid  = !w_empty;
    assign client_id  = w_head.client_id;
    assign amount     = w_head.amount;
    assign msg_count  = r_msg_count;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire
